// File: rtl/i2c_burst_ctrl.sv
// rtl/i2c_burst_ctrl.sv - multi-byte I2C transaction sequencer with TX/RX FIFOs
// Optional feature: define I2C_BURST_NACK_ABORT_EN to abort a write with STOP on a data-byte NACK.
module i2c_burst_ctrl #(
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                          Clk,
   input  logic                          Rst_n,
   input  logic                          Go,
   input  logic [6:0]                    SlaveAddr,
   input  logic                          Rnw,
   input  logic [LEN_WIDTH-1:0]          Len,
   input  logic                          TxPush,
   input  logic [7:0]                    TxData,
   input  logic                          RxPop,
   output logic [7:0]                    RxData,
   output logic [$clog2(FIFO_DEPTH):0]   TxLevel,
   output logic [$clog2(FIFO_DEPTH):0]   RxLevel,
   output logic                          Busy,
   output logic                          Done,
   output logic                          Nack,
   output logic                          Al,
   output logic                          Start,
   output logic                          Stop,
   output logic                          Read,
   output logic                          Write,
   output logic                          Tx_ack,
   output logic [7:0]                    Tx_data,
   input  logic [7:0]                    Rx_data,
   input  logic                          Rx_ack,
   input  logic                          I2C_done,
   input  logic                          I2C_al
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_GAP,
      S_WDATA,
      S_RDATA,
      S_STOP
   } state_t;

   state_t               state;
   logic                 rnw_q;
   logic [LEN_WIDTH-1:0] cnt;
   logic                 last;

   logic [7:0]           tx_mem [FIFO_DEPTH];
   logic [AW-1:0]        tx_wr;
   logic [AW-1:0]        tx_rd;
   logic                 tx_full;
   logic                 tx_empty;
   logic                 tx_push;
   logic                 tx_pop;
   logic [7:0]           tx_head;

   logic [7:0]           rx_mem [FIFO_DEPTH];
   logic [AW-1:0]        rx_wr;
   logic [AW-1:0]        rx_rd;
   logic                 rx_full;
   logic                 rx_empty;
   logic                 rx_push;
   logic                 rx_pop;

   assign last     = (cnt == LEN_WIDTH'(1));

   assign tx_full  = (TxLevel == LW'(FIFO_DEPTH));
   assign tx_empty = (TxLevel == '0);
   assign tx_push  = TxPush && !tx_full;
   assign tx_pop   = (state == S_WDATA) && Write && I2C_done && !I2C_al && !tx_empty;
   assign tx_head  = tx_mem[tx_rd];

   assign rx_full  = (RxLevel == LW'(FIFO_DEPTH));
   assign rx_empty = (RxLevel == '0);
   assign rx_push  = (state == S_RDATA) && Read && I2C_done && !I2C_al && !rx_full;
   assign rx_pop   = RxPop && !rx_empty;
   assign RxData   = rx_empty ? 8'h00 : rx_mem[rx_rd];

   always_ff @(posedge Clk) begin
      if (tx_push) begin
         tx_mem[tx_wr] <= TxData;
      end
      if (rx_push) begin
         rx_mem[rx_wr] <= Rx_data;
      end
   end

   // Fullness is judged before the same-cycle pop, so a push into a full FIFO is always lost.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         tx_wr   <= '0;
         tx_rd   <= '0;
         TxLevel <= '0;
      end else begin
         if (tx_push) begin
            tx_wr <= tx_wr + AW'(1);
         end
         if (tx_pop) begin
            tx_rd <= tx_rd + AW'(1);
         end
         case ({tx_push, tx_pop})
            2'b10:   TxLevel <= TxLevel + LW'(1);
            2'b01:   TxLevel <= TxLevel - LW'(1);
            default: TxLevel <= TxLevel;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rx_wr   <= '0;
         rx_rd   <= '0;
         RxLevel <= '0;
      end else begin
         if (rx_push) begin
            rx_wr <= rx_wr + AW'(1);
         end
         if (rx_pop) begin
            rx_rd <= rx_rd + AW'(1);
         end
         case ({rx_push, rx_pop})
            2'b10:   RxLevel <= RxLevel + LW'(1);
            2'b01:   RxLevel <= RxLevel - LW'(1);
            default: RxLevel <= RxLevel;
         endcase
      end
   end

   // The registered Stop doubles as the "this byte ends the transaction" flag.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state   <= S_IDLE;
         rnw_q   <= 1'b0;
         cnt     <= '0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         Nack    <= 1'b0;
         Al      <= 1'b0;
         Start   <= 1'b0;
         Stop    <= 1'b0;
         Read    <= 1'b0;
         Write   <= 1'b0;
         Tx_ack  <= 1'b0;
         Tx_data <= 8'h00;
      end else begin
         Done <= 1'b0;
         if ((state != S_IDLE) && I2C_al) begin
            Al     <= 1'b1;
            Start  <= 1'b0;
            Stop   <= 1'b0;
            Read   <= 1'b0;
            Write  <= 1'b0;
            Tx_ack <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b1;
            state  <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (Go) begin
                     rnw_q   <= Rnw;
                     cnt     <= Len;
                     Nack    <= 1'b0;
                     Al      <= 1'b0;
                     Busy    <= 1'b1;
                     Start   <= 1'b1;
                     Write   <= 1'b1;
                     Stop    <= (Len == '0);
                     Tx_data <= {SlaveAddr, Rnw};
                     state   <= S_ADDR;
                  end
               end

               S_ADDR: begin
                  if (I2C_done) begin
                     Start <= 1'b0;
                     Write <= 1'b0;
                     Stop  <= 1'b0;
                     if (Rx_ack) begin
                        Nack <= 1'b1;
                     end
                     if (Stop) begin
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= S_IDLE;
                     end else if (Rx_ack) begin
                        state <= S_STOP;
                     end else begin
                        state <= S_GAP;
                     end
                  end
               end

               S_GAP: begin
                  state <= rnw_q ? S_RDATA : S_WDATA;
               end

               S_WDATA: begin
                  if (!Write) begin
                     if (!tx_empty) begin
                        Write   <= 1'b1;
                        Stop    <= last;
                        Tx_data <= tx_head;
                     end
                  end else if (I2C_done) begin
                     Write <= 1'b0;
                     Stop  <= 1'b0;
                     cnt   <= cnt - LEN_WIDTH'(1);
                     if (Rx_ack) begin
                        Nack <= 1'b1;
                     end
                     if (Stop) begin
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= S_IDLE;
`ifdef I2C_BURST_NACK_ABORT_EN
                     end else if (Rx_ack) begin
                        state <= S_STOP;
`endif
                     end else begin
                        state <= S_GAP;
                     end
                  end
               end

               S_RDATA: begin
                  if (!Read) begin
                     if (!rx_full) begin
                        Read   <= 1'b1;
                        Tx_ack <= last;
                        Stop   <= last;
                     end
                  end else if (I2C_done) begin
                     Read   <= 1'b0;
                     Stop   <= 1'b0;
                     Tx_ack <= 1'b0;
                     cnt    <= cnt - LEN_WIDTH'(1);
                     if (Stop) begin
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= S_IDLE;
                     end else begin
                        state <= S_GAP;
                     end
                  end
               end

               S_STOP: begin
                  if (!Stop) begin
                     Stop <= 1'b1;
                  end else if (I2C_done) begin
                     Stop  <= 1'b0;
                     Busy  <= 1'b0;
                     Done  <= 1'b1;
                     state <= S_IDLE;
                  end
               end

               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
